ysyx_24110006_alu_exec: RTL and testbench

//  Execute-stage ALU for the RV32 NPC core. It decodes opcode/func3/func7 directly and

---
 rtl/ysyx_24110006_alu_exec.sv | 260 ++++++++++++++++++++++++++
 tb/tb_ysyx_24110006_alu_exec.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110006_alu_exec.sv
// ysyx_24110006_alu_exec: RV32 execute-stage ALU with valid/ready handshakes on both sides.
// Define YSYX_24110006_MDU_EN to build the iterative RV32M mul/div datapath.
module ysyx_24110006_alu_exec #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DIV_UNROLL = 1,
  parameter int unsigned MUL_SEQ    = 0
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [6:0]      i_op,
  input  logic [2:0]      i_func,
  input  logic [6:0]      i_func7,
  input  logic [XLEN-1:0] i_src1,
  input  logic [XLEN-1:0] i_src2,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_csr_rdata,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_illegal
);
  localparam int unsigned SHW = $clog2(XLEN);

  localparam logic [6:0] OpLui   = 7'b0110111;
  localparam logic [6:0] OpAuipc = 7'b0010111;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpBr    = 7'b1100011;
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpReg   = 7'b0110011;
  localparam logic [6:0] OpFence = 7'b0001111;
  localparam logic [6:0] OpSys   = 7'b1110011;

  typedef enum logic [1:0] {
    StIdle,
`ifdef YSYX_24110006_MDU_EN
    StExec,
`endif
    StDone
  } state_e;

  state_e            r_state, w_state_nxt;
  logic [XLEN-1:0]   r_result;
  logic              r_illegal;
  logic              w_accept, w_is_mext;
  logic              w_lui, w_auipc, w_jal, w_jalr, w_br, w_load, w_store, w_opimm, w_op;
  logic              w_fence, w_sys, w_sra;
  logic [XLEN-1:0]   w_a, w_b, w_sum, w_diff, w_base, w_acc_result;
  logic [SHW-1:0]    w_shamt;
  logic              w_base_illegal;

  assign w_lui     = (i_op == OpLui);
  assign w_auipc   = (i_op == OpAuipc);
  assign w_jal     = (i_op == OpJal);
  assign w_jalr    = (i_op == OpJalr);
  assign w_br      = (i_op == OpBr);
  assign w_load    = (i_op == OpLoad);
  assign w_store   = (i_op == OpStore);
  assign w_opimm   = (i_op == OpImm);
  assign w_op      = (i_op == OpReg);
  assign w_fence   = (i_op == OpFence);
  assign w_sys     = (i_op == OpSys);
  assign w_is_mext = w_op && (i_func7 == 7'b0000001);
  assign w_accept  = i_valid && (r_state == StIdle);

  always_comb begin
    w_a = i_src1;
    if (w_jal || w_jalr || w_auipc) w_a = i_pc;
    else if (w_lui)                 w_a = '0;
  end

  always_comb begin
    w_b = i_src2;
    if (w_opimm || w_load || w_store || w_auipc || w_lui) w_b = i_imm;
    else if (w_jal || w_jalr)                             w_b = XLEN'(4);
    else if (w_sys && i_func == 3'b001)                   w_b = '0;
    else if (w_sys && i_func == 3'b010)                   w_b = i_csr_rdata;
  end

  assign w_sum   = w_a + w_b;
  assign w_diff  = w_a - w_b;
  assign w_shamt = w_b[SHW-1:0];
  assign w_sra   = w_op ? i_func7[5] : i_imm[10];

  always_comb begin
    w_base         = w_sum;
    w_base_illegal = 1'b0;
    if (w_is_mext) begin
      w_base = '0;
`ifndef YSYX_24110006_MDU_EN
      w_base_illegal = 1'b1;
`endif
    end else if (w_op || w_opimm) begin
      case (i_func)
        3'b000: w_base = (w_op && i_func7[5]) ? w_diff : w_sum;
        3'b001: w_base = w_a << w_shamt;
        3'b010: w_base = {{(XLEN-1){1'b0}}, $signed(w_a) < $signed(w_b)};
        3'b011: w_base = {{(XLEN-1){1'b0}}, w_a < w_b};
        3'b100: w_base = w_a ^ w_b;
        3'b101: begin
          // Kept out of a ?: so the signed operand is not coerced to unsigned.
          if (w_sra) w_base = $signed(w_a) >>> w_shamt;
          else       w_base = w_a >> w_shamt;
        end
        3'b110: w_base = w_a | w_b;
        3'b111: w_base = w_a & w_b;
      endcase
    end else if (w_br) begin
      w_base = w_diff;
    end else if (w_fence) begin
      w_base = '0;
    end else if (w_sys) begin
      if (i_func == 3'b010)      w_base = w_a | w_b;
      else if (i_func == 3'b001) w_base = w_sum;
      else                       w_base = '0;
    end else if (!(w_lui || w_auipc || w_jal || w_jalr || w_load || w_store)) begin
      w_base         = '0;
      w_base_illegal = 1'b1;
    end
  end

`ifdef YSYX_24110006_MDU_EN
  localparam int unsigned     CW     = $clog2(XLEN + 2);
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  logic [2:0]        r_mfunc;
  logic              r_neg_q, r_neg_r;
  logic [XLEN-1:0]   r_mag_a, r_mag_b, r_quo;
  logic [XLEN:0]     r_rem;
  logic [2*XLEN-1:0] r_prod;
  logic [CW-1:0]     r_cnt;
  logic              w_sgn_a, w_sgn_b, w_div_zero, w_div_ovf, w_special;
  logic [XLEN-1:0]   w_mag_a, w_mag_b, w_spec_res, w_quo_nxt, w_quo_fix, w_rem_fix;
  logic [XLEN-1:0]   w_mdu_result;
  logic [XLEN:0]     w_rem_nxt, w_add;
  logic [2*XLEN-1:0] w_prod_step, w_prod_full, w_prod_nxt, w_prod_fix;

  // Divide ops: signed unless func3[0]; mulh/mulhsu take rs1 signed, only mulh takes rs2 signed.
  assign w_sgn_a    = i_func[2] ? ~i_func[0] : (i_func[1:0] == 2'b01 || i_func[1:0] == 2'b10);
  assign w_sgn_b    = i_func[2] ? ~i_func[0] : (i_func[1:0] == 2'b01);
  assign w_mag_a    = (w_sgn_a && i_src1[XLEN-1]) ? -i_src1 : i_src1;
  assign w_mag_b    = (w_sgn_b && i_src2[XLEN-1]) ? -i_src2 : i_src2;
  assign w_div_zero = (i_src2 == '0);
  assign w_div_ovf  = ~i_func[0] && (i_src1 == MinInt) && (i_src2 == '1);
  assign w_special  = w_is_mext && i_func[2] && (w_div_zero || w_div_ovf);
  assign w_spec_res = w_div_zero ? (i_func[1] ? i_src1 : '1) : (i_func[1] ? '0 : i_src1);
  assign w_acc_result = w_special ? w_spec_res : w_base;

  always_comb begin
    w_quo_nxt = r_quo;
    w_rem_nxt = r_rem;
    for (int unsigned i = 0; i < DIV_UNROLL; i++) begin
      w_rem_nxt = {w_rem_nxt[XLEN-1:0], w_quo_nxt[XLEN-1]};
      w_quo_nxt = {w_quo_nxt[XLEN-2:0], 1'b0};
      if (w_rem_nxt >= {1'b0, r_mag_b}) begin
        w_rem_nxt    = w_rem_nxt - {1'b0, r_mag_b};
        w_quo_nxt[0] = 1'b1;
      end
    end
  end

  assign w_add       = {1'b0, r_prod[2*XLEN-1:XLEN]} + (r_prod[0] ? {1'b0, r_mag_a} : '0);
  assign w_prod_step = {w_add, r_prod[XLEN-1:1]};
  assign w_prod_full = {{XLEN{1'b0}}, r_mag_a} * {{XLEN{1'b0}}, r_mag_b};
  assign w_prod_nxt  = (MUL_SEQ != 0) ? w_prod_step : w_prod_full;
  assign w_prod_fix  = r_neg_q ? -w_prod_nxt : w_prod_nxt;
  assign w_quo_fix   = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix   = r_neg_r ? -r_rem[XLEN-1:0] : r_rem[XLEN-1:0];

  always_comb begin
    if (r_mfunc[2])                w_mdu_result = r_mfunc[1] ? w_rem_fix : w_quo_fix;
    else if (r_mfunc[1:0] == 2'b00) w_mdu_result = w_prod_fix[XLEN-1:0];
    else                            w_mdu_result = w_prod_fix[2*XLEN-1:XLEN];
  end

  // Divide runs XLEN/DIV_UNROLL iterations plus a sign-fix cycle; multiply folds the fix
  // into its last step.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_mfunc <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_mfunc <= i_func;
      r_neg_q <= (w_sgn_a & i_src1[XLEN-1]) ^ (w_sgn_b & i_src2[XLEN-1]);
      r_neg_r <= w_sgn_a & i_src1[XLEN-1];
      r_mag_a <= w_mag_a;
      r_mag_b <= w_mag_b;
      r_quo   <= w_mag_a;
      r_rem   <= '0;
      r_prod  <= {{XLEN{1'b0}}, w_mag_b};
      r_cnt   <= i_func[2] ? CW'(XLEN / DIV_UNROLL + 1) : ((MUL_SEQ != 0) ? CW'(XLEN) : CW'(1));
    end else if (r_state == StExec) begin
      r_cnt  <= r_cnt - CW'(1);
      r_quo  <= w_quo_nxt;
      r_rem  <= w_rem_nxt;
      r_prod <= w_prod_nxt;
    end
  end
`else
  logic [31:0] w_unused_cfg;
  assign w_unused_cfg = DIV_UNROLL + MUL_SEQ;
  assign w_acc_result = w_base;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_valid) begin
          w_state_nxt = StDone;
`ifdef YSYX_24110006_MDU_EN
          if (w_is_mext && !w_special) w_state_nxt = StExec;
`endif
        end
      end
`ifdef YSYX_24110006_MDU_EN
      StExec:  if (r_cnt == CW'(1)) w_state_nxt = StDone;
`endif
      StDone:  if (i_ready) w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= StIdle;
      r_result  <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_result  <= w_acc_result;
        r_illegal <= w_base_illegal;
      end
`ifdef YSYX_24110006_MDU_EN
      else if (r_state == StExec && r_cnt == CW'(1)) begin
        r_result <= w_mdu_result;
      end
`endif
    end
  end

  assign o_ready   = (r_state == StIdle);
  assign o_valid   = (r_state == StDone);
  assign o_result  = r_result;
  assign o_illegal = r_illegal;

endmodule

// File: tb/tb_ysyx_24110006_alu_exec.sv
// Scoreboard bench for ysyx_24110006_alu_exec; expectations follow YSYX_24110006_MDU_EN.
module tb_ysyx_24110006_alu_exec;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned DIV_UNROLL = 1;
  localparam int unsigned MUL_SEQ    = 0;
  localparam int          MUL_LAT    = (MUL_SEQ != 0) ? XLEN + 1 : 2;
  localparam int          DIV_LAT    = XLEN / DIV_UNROLL + 2;
`ifdef YSYX_24110006_MDU_EN
  localparam bit MDU_ON = 1'b1;
`else
  localparam bit MDU_ON = 1'b0;
`endif

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_REG = 7'b0110011;

  logic        clock = 1'b0;
  logic        reset_n, i_valid, i_ready, o_ready, o_valid, o_illegal;
  logic [6:0]  i_op, i_func7;
  logic [2:0]  i_func;
  logic [31:0] i_src1, i_src2, i_imm, i_pc, i_csr_rdata, o_result;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  ysyx_24110006_alu_exec #(
    .XLEN      (XLEN),
    .DIV_UNROLL(DIV_UNROLL),
    .MUL_SEQ   (MUL_SEQ)
  ) u_dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_op       (i_op),
    .i_func     (i_func),
    .i_func7    (i_func7),
    .i_src1     (i_src1),
    .i_src2     (i_src2),
    .i_imm      (i_imm),
    .i_pc       (i_pc),
    .i_csr_rdata(i_csr_rdata),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
    .o_illegal  (o_illegal)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] imm,
                       input logic [31:0] pc, input logic [31:0] csr,
                       input logic [31:0] exp_res, input logic exp_ill, input int lat,
                       input string name);
    exp_t e;
    int   n = 0;
    while (!o_ready && n < 200) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!o_ready) begin
      check({"ready_timeout_", name}, 32'(o_ready), 32'd1);
      return;
    end
    i_op = op; i_func = f3; i_func7 = f7; i_src1 = s1; i_src2 = s2;
    i_imm = imm; i_pc = pc; i_csr_rdata = csr; i_valid = 1'b1;
    @(posedge clock);
    #1;
    e.res = exp_res; e.ill = exp_ill; e.lat = lat; e.acc = cyc; e.name = name;
    sb.push_back(e);
    // Inputs are don't-care once accepted.
    i_valid = 1'b0;
    i_op = 7'($urandom); i_func = 3'($urandom); i_func7 = 7'($urandom);
    i_src1 = $urandom; i_src2 = $urandom; i_imm = $urandom; i_pc = $urandom;
    i_csr_rdata = $urandom;
  endtask

  task automatic issue_m(input logic [2:0] f3, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [31:0] exp_res, input int lat, input string name);
    issue(OP_REG, f3, 7'b0000001, s1, s2, 32'h0, 32'h0, 32'h0,
          MDU_ON ? exp_res : 32'h0, !MDU_ON, MDU_ON ? lat : 1, name);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    check({"drain_", name}, sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: scores each result the first cycle it appears, then checks it stays put.
  initial begin
    exp_t cur;
    bit   prev_v = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        prev_v = 1'b0;
      end else begin
        if (o_valid) begin
          if (!prev_v) begin
            if (sb.size() == 0) begin
              check("unexpected_valid", 32'(o_valid), 32'd0);
              cur.res = o_result; cur.ill = o_illegal; cur.name = "none";
            end else begin
              cur = sb[0];
              check({"lat_", cur.name}, cyc - cur.acc + 1, cur.lat);
              check({"res_", cur.name}, o_result, cur.res);
              check({"ill_", cur.name}, 32'(o_illegal), 32'(cur.ill));
            end
          end else begin
            check({"hold_res_", cur.name}, o_result, cur.res);
            check({"hold_rdy_", cur.name}, 32'(o_ready), 32'd0);
          end
          if (i_ready && sb.size() != 0) void'(sb.pop_front());
        end
        prev_v = o_valid && !i_ready;
      end
    end
  end

  initial begin
    int n;
    reset_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_op = '0; i_func = '0; i_func7 = '0; i_src1 = '0; i_src2 = '0;
    i_imm = '0; i_pc = '0; i_csr_rdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_result", o_result, 32'h0);
    check("rst_illegal", 32'(o_illegal), 32'd0);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    check("rst_ready", 32'(o_ready), 32'd1);

    // Base integer ops
    issue(OP_IMM, 3'b000, 7'h00, 32'd5, 32'h0, 32'hFFFF_FFFD, 32'h0, 32'h0,
          32'd2, 1'b0, 1, "addi"); drain("addi");
    issue(OP_IMM, 3'b101, 7'h00, 32'h8000_0000, 32'h0, 32'h0000_0404, 32'h0, 32'h0,
          32'hF800_0000, 1'b0, 1, "srai"); drain("srai");
    issue(OP_IMM, 3'b101, 7'h00, 32'h8000_0000, 32'h0, 32'h0000_0004, 32'h0, 32'h0,
          32'h0800_0000, 1'b0, 1, "srli"); drain("srli");
    issue(OP_REG, 3'b000, 7'h20, 32'd3, 32'd5, 32'h0, 32'h0, 32'h0,
          32'hFFFF_FFFE, 1'b0, 1, "sub"); drain("sub");
    issue(OP_REG, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 32'h0,
          32'd1, 1'b0, 1, "slt"); drain("slt");
    issue(OP_REG, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0, 32'h0,
          32'd0, 1'b0, 1, "sltu"); drain("sltu");
    issue(OP_REG, 3'b001, 7'h00, 32'd1, 32'h21, 32'h0, 32'h0, 32'h0,
          32'd2, 1'b0, 1, "sll"); drain("sll");
    issue(7'b0110111, 3'b000, 7'h00, 32'h5555_5555, 32'h0, 32'h1234_5000, 32'h0, 32'h0,
          32'h1234_5000, 1'b0, 1, "lui"); drain("lui");
    issue(7'b0010111, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0000_1000, 32'h8000_0000, 32'h0,
          32'h8000_1000, 1'b0, 1, "auipc"); drain("auipc");
    issue(7'b1101111, 3'b000, 7'h00, 32'h0, 32'h0, 32'h0000_0100, 32'h8000_0010, 32'h0,
          32'h8000_0014, 1'b0, 1, "jal"); drain("jal");
    issue(7'b1100011, 3'b000, 7'h00, 32'd10, 32'd3, 32'h0, 32'h0, 32'h0,
          32'd7, 1'b0, 1, "beq"); drain("beq");
    issue(7'b1110011, 3'b001, 7'h00, 32'hDEAD_BEEF, 32'h1, 32'h0, 32'h0, 32'h1234_5678,
          32'hDEAD_BEEF, 1'b0, 1, "csrrw"); drain("csrrw");
    issue(7'b0001111, 3'b001, 7'h00, 32'h1234_5678, 32'h1, 32'h5, 32'h0, 32'h0,
          32'h0, 1'b0, 1, "fence_i"); drain("fence_i");
    issue(7'b1111111, 3'b000, 7'h00, 32'd7, 32'd9, 32'h0, 32'h0, 32'h0,
          32'h0, 1'b1, 1, "bad_op"); drain("bad_op");

    // M extension: special-case divides, then iterative mul/div
    issue_m(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    drain("div_ovf");
    issue_m(3'b111, 32'd7, 32'd0, 32'd7, 1, "remu_zero"); drain("remu_zero");
    issue_m(3'b101, 32'd7, 32'd0, 32'hFFFF_FFFF, 1, "divu_zero"); drain("divu_zero");
    issue_m(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, MUL_LAT, "mulh"); drain("mulh");
    issue_m(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu");
    drain("mulhu");
    issue_m(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, "mulhsu");
    drain("mulhsu");
    issue_m(3'b000, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, MUL_LAT, "mul"); drain("mul");
    issue_m(3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, DIV_LAT, "rem"); drain("rem");

    // Result held while downstream stalls
    i_ready = 1'b0;
    issue_m(3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, DIV_LAT, "div_stall");
    n = 0;
    while (!o_valid && n < 100) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("stall_valid_seen", 32'(o_valid), 32'd1);
    repeat (5) begin
      @(posedge clock);
      #1;
    end
    i_ready = 1'b1;
    drain("div_stall");

    // Reset mid-operation discards it
    i_ready = 1'b0;
    issue_m(3'b100, 32'd100, 32'd7, 32'd14, DIV_LAT, "div_reset");
    repeat (3) begin
      @(posedge clock);
      #1;
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(o_valid), 32'd0);
    check("mid_rst_result", o_result, 32'h0);
    sb.delete();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    i_ready = 1'b1;
    #2;
    check("post_rst_ready", 32'(o_ready), 32'd1);
    issue(OP_REG, 3'b000, 7'h00, 32'd1, 32'd1, 32'h0, 32'h0, 32'h0,
          32'd2, 1'b0, 1, "add_after_rst"); drain("add_after_rst");

    repeat (3) @(posedge clock);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
